// File: rtl/cache_ctrl_dm_if.sv
// Request/response and RAM-strobe bundle for the direct-mapped cache controller.
// The RAM data bus is kept off this bundle as a plain inout port on the
// controller, so it stays a simple resolved wire between controller and RAM.
interface cache_ctrl_dm_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic [15:0]           hit_count;
    logic [15:0]           miss_count;

    // Controller side: takes CPU requests, drives responses, RAM strobes and counters
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, flush,
        output req_ready, resp_valid, resp_rdata,
        output mem_addr, mem_cs, mem_we, mem_oe,
        output hit_count, miss_count
    );

    // CPU side: issues requests and flushes, observes everything else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, flush,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_addr, mem_cs, mem_we, mem_oe,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, single-word-line cache controller.
// Read hits are answered from local storage, read misses refill one line from
// the synchronous RAM, and every write is forwarded to RAM (no write-allocate).
// Hit and read-miss counters saturate at all-ones.
module cache_ctrl_dm #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 4,
    parameter int MEM_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_ctrl_dm_if.slave        bus,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    localparam int         LINES     = 1 << INDEX_WIDTH;
    localparam int         TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
    localparam logic [2:0] LAT_LAST  = 3'(MEM_LAT);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR,
        FLUSH
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_hit;
    logic [2:0]             r_cnt;
    logic                   r_flushPend;

    logic [LINES-1:0]       r_valid;
    logic [TAG_WIDTH-1:0]   r_tag  [LINES];
    logic [DATA_WIDTH-1:0]  r_data [LINES];

    logic                   r_respValid;
    logic [DATA_WIDTH-1:0]  r_respRdata;
    logic                   r_memCs;
    logic                   r_memWe;
    logic                   r_memOe;
    logic [ADDR_WIDTH-1:0]  r_memAddr;
    logic [15:0]            r_hitCount;
    logic [15:0]            r_missCount;

    logic [INDEX_WIDTH-1:0] w_index;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic                   w_hit;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_flushReq;
    logic                   w_rdDone;
    logic                   w_lookupRdHit;

    assign w_index       = r_addr[INDEX_WIDTH-1:0];
    assign w_tag         = r_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_flushReq    = bus.flush || r_flushPend;
    assign w_accept      = w_ready && bus.req_valid;
    assign w_rdDone      = (r_state == MEM_RD) && (r_cnt == LAT_LAST);
    assign w_lookupRdHit = (r_state == LOOKUP) && !r_we && w_hit;

    // State register; reset aborts any RAM access and returns to IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and ready decode; a flush in IDLE always beats a request
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_flushReq) begin
                    w_next = FLUSH;
                end else begin
                    w_ready = rst_n;
                    if (bus.req_valid && rst_n) begin
                        w_next = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (r_we) begin
                    w_next = MEM_WR;
                end else if (w_hit) begin
                    w_next = IDLE;
                end else begin
                    w_next = MEM_RD;
                end
            end
            MEM_RD: begin
                if (w_rdDone) begin
                    w_next = IDLE;
                end
            end
            MEM_WR:  w_next = IDLE;
            FLUSH:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request capture, lookup result and RAM read wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == LOOKUP) begin
                r_hit <= w_hit;
            end
            if (r_state == MEM_RD) begin
                r_cnt <= r_cnt + 3'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Valid bits and the pending-flush latch; a flush seen mid-transaction waits for IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= '0;
            r_flushPend <= 1'b0;
        end else begin
            if (r_state == FLUSH) begin
                r_valid     <= '0;
                r_flushPend <= 1'b0;
            end else begin
                if (w_rdDone) begin
                    r_valid[w_index] <= 1'b1;
                end
                if (bus.flush && (r_state != IDLE)) begin
                    r_flushPend <= 1'b1;
                end
            end
        end
    end

    // Tag and data arrays: refill on read miss, update data on write hit
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_rdDone) begin
                r_data[w_index] <= mem_data;
                r_tag[w_index]  <= w_tag;
            end else if ((r_state == MEM_WR) && r_hit) begin
                r_data[w_index] <= r_wdata;
            end
        end
    end

    // Registered RAM strobes, derived from the state being entered so they are glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_memCs   <= 1'b0;
            r_memWe   <= 1'b0;
            r_memOe   <= 1'b0;
            r_memAddr <= '0;
        end else begin
            r_memCs <= (w_next == MEM_RD) || (w_next == MEM_WR);
            r_memOe <= (w_next == MEM_RD);
            r_memWe <= (w_next == MEM_WR);
            if (r_state == LOOKUP) begin
                r_memAddr <= r_addr;
            end
        end
    end

    // One-cycle response pulse; read data is zero except on a read response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_respValid <= 1'b0;
            r_respRdata <= '0;
        end else begin
            r_respValid <= w_lookupRdHit || w_rdDone || (r_state == MEM_WR);
            if (w_lookupRdHit) begin
                r_respRdata <= r_data[w_index];
            end else if (w_rdDone) begin
                r_respRdata <= mem_data;
            end else begin
                r_respRdata <= '0;
            end
        end
    end

    // Saturating counters: any lookup hit counts as a hit, only read misses count as misses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else if (r_state == LOOKUP) begin
            if (w_hit) begin
                if (r_hitCount != 16'hFFFF) begin
                    r_hitCount <= r_hitCount + 16'd1;
                end
            end else if (!r_we) begin
                if (r_missCount != 16'hFFFF) begin
                    r_missCount <= r_missCount + 16'd1;
                end
            end
        end
    end

    assign mem_data       = r_memWe ? r_wdata : {DATA_WIDTH{1'bz}};
    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_rdata = r_respRdata;
    assign bus.mem_addr   = r_memAddr;
    assign bus.mem_cs     = r_memCs;
    assign bus.mem_we     = r_memWe;
    assign bus.mem_oe     = r_memOe;
    assign bus.hit_count  = r_hitCount;
    assign bus.miss_count = r_missCount;

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Testbench for cache_ctrl_dm: behavioural RAM with read latency, a line-level
// cache model, directed scenarios followed by randomized requests and flushes.
module tb_cache_ctrl_dm;

    localparam int AW      = 12;
    localparam int DW      = 16;
    localparam int IW      = 4;
    localparam int LINES   = 1 << IW;
    localparam int MEM_LAT = 1;

    logic          clk = 1'b0;
    logic          rstN;
    wire  [DW-1:0] memData;

    cache_ctrl_dm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cache_ctrl_dm #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW),
        .MEM_LAT    (MEM_LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rstN),
        .bus     (bus),
        .mem_data(memData)
    );

    always #5 clk = ~clk;

    // RAM model: data appears MEM_LAT cycles after the read strobes rise, garbage before
    logic [DW-1:0] ramMem [4096];
    int            oeCnt = 0;
    logic          ramDrive;
    logic [DW-1:0] ramQ;

    assign ramDrive = bus.mem_cs && bus.mem_oe && !bus.mem_we;
    assign ramQ     = (oeCnt >= MEM_LAT) ? ramMem[bus.mem_addr] : 16'hDEAD;
    assign memData  = ramDrive ? ramQ : {DW{1'bz}};

    // RAM write port and read-latency counter
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) begin
            ramMem[bus.mem_addr] <= memData;
        end
        if (ramDrive) begin
            oeCnt <= oeCnt + 1;
        end else begin
            oeCnt <= 0;
        end
    end

    // Reference model of cache contents, backing memory and counters
    bit          mValid [LINES];
    logic [7:0]  mTag   [LINES];
    logic [15:0] mData  [LINES];
    logic [15:0] refRam [4096];
    int          expHits;
    int          expMisses;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void modelFlush();
        for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
    endfunction

    function automatic void modelReset();
        modelFlush();
        expHits   = 0;
        expMisses = 0;
    endfunction

    function automatic int satInc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic waitReady();
        int waitCyc;
        waitCyc = 0;
        while (bus.req_ready !== 1'b1 && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
    endtask

    // One full request/response transaction, checked against the model; optionally
    // pulses flush during the lookup cycle so it must be held pending
    task automatic applyStimulus(input bit we, input logic [11:0] addr,
                                 input logic [15:0] wdata, input bit flushMid);
        int          idx;
        logic [7:0]  tg;
        bit          expHit;
        int          expLat;
        int          expOe;
        logic [15:0] expData;
        int          lat;
        int          oeCyc;
        int          weCyc;
        bit          gotResp;
        bit          addrBad;
        bit          wrBad;
        bit          overlap;
        logic [15:0] gotData;

        idx    = int'(addr[3:0]);
        tg     = addr[11:4];
        expHit = mValid[idx] && (mTag[idx] == tg);
        expOe  = 0;
        if (we) begin
            expLat  = 3;
            expData = 16'h0000;
        end else if (expHit) begin
            expLat  = 2;
            expData = mData[idx];
        end else begin
            expLat  = MEM_LAT + 3;
            expData = refRam[addr];
            expOe   = MEM_LAT + 1;
        end

        waitReady();
        checkOutput("readyBeforeReq", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;

        lat = 0; oeCyc = 0; weCyc = 0; gotResp = 0;
        addrBad = 0; wrBad = 0; overlap = 0; gotData = '0;
        while (!gotResp && lat < 30) begin
            lat++;
            bus.flush = flushMid && (lat == 1);
            #1;
            if (bus.mem_cs && bus.mem_oe) oeCyc++;
            if (bus.mem_oe && bus.mem_we) overlap = 1;
            if (bus.mem_cs && bus.mem_we) begin
                weCyc++;
                if (memData !== wdata) wrBad = 1;
            end
            if (bus.mem_cs && bus.mem_addr !== addr) addrBad = 1;
            if (bus.resp_valid) begin
                gotResp = 1;
                gotData = bus.resp_rdata;
            end else begin
                @(negedge clk);
            end
        end
        bus.flush = 1'b0;

        checkOutput("respSeen",   {31'd0, gotResp}, 32'd1);
        checkOutput("latency",    lat, expLat);
        checkOutput("rdata",      {16'd0, gotData}, {16'd0, expData});
        checkOutput("oeCycles",   oeCyc, expOe);
        checkOutput("weCycles",   weCyc, we ? 1 : 0);
        checkOutput("memAddr",    {31'd0, addrBad}, 32'd0);
        checkOutput("oeWeExcl",   {31'd0, overlap}, 32'd0);
        if (we) checkOutput("wrBusData", {31'd0, wrBad}, 32'd0);

        @(negedge clk);
        checkOutput("respPulse", {31'd0, bus.resp_valid}, 32'd0);

        if (we) begin
            refRam[addr] = wdata;
            if (expHit) begin
                mData[idx] = wdata;
                expHits    = satInc(expHits);
            end
            checkOutput("ramWord", {16'd0, ramMem[addr]}, {16'd0, wdata});
        end else if (expHit) begin
            expHits = satInc(expHits);
        end else begin
            expMisses   = satInc(expMisses);
            mValid[idx] = 1'b1;
            mTag[idx]   = tg;
            mData[idx]  = refRam[addr];
        end
        if (flushMid) modelFlush();

        checkOutput("hitCount",  {16'd0, bus.hit_count},  expHits);
        checkOutput("missCount", {16'd0, bus.miss_count}, expMisses);
    endtask

    logic [7:0] tagPool [4];

    initial begin
        logic [15:0] v;
        logic [11:0] rAddr;
        bit          rWe;

        tagPool[0] = 8'h12; tagPool[1] = 8'h22; tagPool[2] = 8'h7F; tagPool[3] = 8'h00;
        for (int i = 0; i < 4096; i++) begin
            v         = 16'($urandom);
            ramMem[i] = v;
            refRam[i] = v;
        end
        ramMem[12'h123] = 16'hBEEF; refRam[12'h123] = 16'hBEEF;
        ramMem[12'h223] = 16'h5A5A; refRam[12'h223] = 16'h5A5A;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.flush     = 1'b0;
        rstN          = 1'b0;
        modelReset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReady",   {31'd0, bus.req_ready},  32'd0);
        checkOutput("rstResp",    {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("rstRdata",   {16'd0, bus.resp_rdata}, 32'd0);
        checkOutput("rstStrobes", {29'd0, bus.mem_cs, bus.mem_oe, bus.mem_we}, 32'd0);
        checkOutput("rstMemAddr", {20'd0, bus.mem_addr}, 32'd0);
        checkOutput("rstHits",    {16'd0, bus.hit_count},  32'd0);
        checkOutput("rstMisses",  {16'd0, bus.miss_count}, 32'd0);
        rstN = 1'b1;
        #1;
        checkOutput("readyAfterReset", {31'd0, bus.req_ready}, 32'd1);

        $display("[TB] directed: miss, hit, write, conflict");
        applyStimulus(1'b0, 12'h123, 16'h0000, 1'b0);
        applyStimulus(1'b0, 12'h123, 16'h0000, 1'b0);
        applyStimulus(1'b1, 12'h123, 16'h1234, 1'b0);
        applyStimulus(1'b0, 12'h123, 16'h0000, 1'b0);
        applyStimulus(1'b0, 12'h223, 16'h0000, 1'b0);
        applyStimulus(1'b0, 12'h123, 16'h0000, 1'b0);

        $display("[TB] directed: flush with simultaneous request");
        waitReady();
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 12'h123;
        #1;
        checkOutput("readyDuringFlush", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        checkOutput("readyInFlush", {31'd0, bus.req_ready}, 32'd0);
        checkOutput("flushNoHit",  {16'd0, bus.hit_count},  expHits);
        checkOutput("flushNoMiss", {16'd0, bus.miss_count}, expMisses);
        modelFlush();
        applyStimulus(1'b0, 12'h123, 16'h0000, 1'b0);

        $display("[TB] directed: reset during RAM read");
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 12'h345;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("oeBeforeReset", {31'd0, bus.mem_oe}, 32'd1);
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abortStrobes", {29'd0, bus.mem_cs, bus.mem_oe, bus.mem_we}, 32'd0);
        checkOutput("abortResp",    {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("abortHits",    {16'd0, bus.hit_count},  32'd0);
        checkOutput("abortMisses",  {16'd0, bus.miss_count}, 32'd0);
        checkOutput("abortReady",   {31'd0, bus.req_ready},  32'd0);
        rstN = 1'b1;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("noRespAfterAbort", {31'd0, bus.resp_valid}, 32'd0);
        end
        applyStimulus(1'b0, 12'h123, 16'h0000, 1'b0);
        applyStimulus(1'b0, 12'h345, 16'h0000, 1'b0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                waitReady();
                bus.flush = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bus.flush = 1'b0;
                modelFlush();
            end else begin
                rWe   = ($urandom_range(0, 2) == 0);
                rAddr = {tagPool[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
                applyStimulus(rWe, rAddr, 16'($urandom), ($urandom_range(0, 7) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_dm.md
Name: cache_ctrl_dm

Overview:
- Direct-mapped, write-through, single-word-line cache controller between the CPU/ALU datapath and the banked 16-bit synchronous RAM (single_port_sync_ram_large).
- Accepts one request at a time over a valid/ready handshake.
- Serves read hits from local storage.
- On a read miss, fetches the word over the RAM's shared inout bus; forwards every write to RAM.
- Keeps saturating hit and miss counters for performance measurement.

Parameters:
- ADDR_WIDTH, 12, word address width; must match the RAM.
- DATA_WIDTH, 16, data word width; must match the RAM.
- INDEX_WIDTH, 4, line index bits; 2^INDEX_WIDTH lines, tag width = ADDR_WIDTH-INDEX_WIDTH.
- MEM_LAT, 1, cycles from RAM strobe assertion to valid read data on mem_data; legal range 1..7.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- resp_valid  output  1  one-cycle pulse: read data valid, or write complete.
- resp_rdata  output  DATA_WIDTH  read data, meaningful only when resp_valid is high.
- flush  input  1  invalidate all lines.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_data  inout  DATA_WIDTH  RAM data bus; driven only while mem_we=1, otherwise high-Z.
- mem_cs  output  1  RAM chip select.
- mem_we  output  1  RAM write enable.
- mem_oe  output  1  RAM output enable.
- hit_count  output  16  saturating hit counter.
- miss_count  output  16  saturating read-miss counter.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; all valid bits cleared.
  - req_ready=0 during reset, then 1 in the first IDLE cycle.
  - resp_valid=0, resp_rdata=0.
  - mem_cs=mem_we=mem_oe=0, mem_addr=0, mem_data released.
  - hit_count=miss_count=0.
  - Reset takes effect from any state, aborting any RAM access in progress.
  - Tag/data arrays need no reset.
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, FLUSH.
- IDLE:
  - req_ready=1 unless flush is high or a flush is pending.
  - Handshake when req_valid&&req_ready at an edge: req_we/req_addr/req_wdata are registered, go to LOOKUP.
  - flush high, or flush pending, in IDLE: go to FLUSH; req_ready=0 that cycle. Flush wins over a simultaneous request.
- FLUSH: one cycle; clears all valid bits; returns to IDLE.
- flush asserted outside IDLE: latched as pending; serviced on the next return to IDLE, before any new request.
- LOOKUP (one cycle): hit = valid[index] && tag[index]==addr tag.
  - Read hit: resp_valid=1 and resp_rdata=line data in the next cycle; hit_count+1; return to IDLE. Latency is 2 cycles from the accept edge to the resp_valid cycle.
  - Read miss: miss_count+1; go to MEM_RD.
  - Write: go to MEM_WR; hit_count+1 if hit. Write misses do not increment miss_count.
- MEM_RD:
  - mem_cs=1, mem_oe=1, mem_we=0, mem_addr=registered addr, for exactly MEM_LAT+1 cycles.
  - 3-bit counter from 0; mem_data sampled at the edge ending the cycle where counter==MEM_LAT.
  - Sampled word is written into the line, the tag is written, valid is set.
  - resp_valid=1 with that word in the following cycle; return to IDLE.
  - Read-miss latency = MEM_LAT+3 cycles from the accept edge.
- MEM_WR:
  - One cycle: mem_cs=1, mem_we=1, mem_oe=0, mem_addr=registered addr, mem_data driven with the registered wdata.
  - If the LOOKUP was a hit, the line data is updated in the same cycle.
  - Write miss: no allocate; line contents unchanged.
  - resp_valid=1 the next cycle (resp_rdata=0); return to IDLE.
- Strobe outputs are registered and glitch-free; mem_oe and mem_we are never both 1.
- Counters saturate at 16'hFFFF without wrap.
- resp_valid has no backpressure and is never high for two consecutive cycles.

Test Plan:
- Reset → read 0x123 (miss), MEM_LAT=1, RAM preloaded 0xBEEF: mem_cs/mem_oe high for 2 cycles; resp_valid 4 cycles after the accept edge with 0xBEEF; miss_count=1.
- Repeat the read of 0x123: no RAM strobes; resp_valid 2 cycles after accept with 0xBEEF; hit_count=1.
- Write 0x123=0x1234, then read 0x123: one mem_we cycle driving 0x1234 on mem_data; read hits and returns 0x1234; RAM word equals 0x1234.
- Read 0x223 (same index, different tag) after 0x123 is cached: miss, refill; a following read of 0x123 misses again; miss_count increments each time.
- Assert flush together with req_valid in IDLE: req_ready=0, FLUSH taken first; the subsequent read of 0x123 misses.
- Assert rst_n=0 during MEM_RD: all strobes 0 after the edge, mem_data high-Z, no resp_valid, counters 0; all lines invalid afterwards.
